muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the 32-bit MIPS core, sitting directly downstream of the register file. It consumes the two register-file read operands (rs, rt) and executes MULT, MULTU, DIV and DIVU over 32 iteration cycles. Results go into its architectural HI/LO registers. It exposes a start/busy/done handshake to the control path, and supports MTHI/MTLO direct writes.

## Interface
- WIDTH, 32: operand width; HI/LO are WIDTH each, product 2*WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request an operation; sampled only when busy=0.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- rs_data  in  WIDTH  operand A (multiplicand / dividend), from register-file read port 1.
- rt_data  in  WIDTH  operand B (multiplier / divisor), from register-file read port 2.
- mthi  in  1  write rs_data into HI.
- mtlo  in  1  write rs_data into LO.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO have just been updated by an operation.
- hi  out  WIDTH  HI register (MULT: upper product; DIV: remainder).
- lo  out  WIDTH  LO register (MULT: lower product; DIV: quotient).

## Operation
- FSM states: IDLE, RUN, FIX.
- Reset: state IDLE, hi=0, lo=0, busy=0, done=0, iteration counter 0.
- IDLE, start=1: latch op, the operand magnitudes (signed ops take absolute values) and the result sign; counter=0; go to RUN.
  - Result sign: quotient/product = signA^signB; remainder = signA.
- RUN: one iteration per cycle, then counter+1; after the iteration with counter=31, go to FIX.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on a WIDTH remainder and WIDTH quotient.
- FIX: apply the two's-complement sign fix; write hi/lo; done=1 for this edge's following cycle; go to IDLE.
- start while busy=1: ignored; no queuing.
- mthi/mtlo: take effect only in IDLE with no accepted start in the same cycle; ignored while busy; both may be asserted together.
- Divide by zero, no trap:
  - DIVU: lo=0xFFFFFFFF, hi=rs.
  - DIV: hi=rs, lo=0xFFFFFFFF if rs>=0, else 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Arithmetic uses unsigned magnitudes internally; abs(0x80000000) is 0x80000000 as an unsigned value.
- Reset mid-operation: aborts immediately and applies all reset values.

## Timing
- Latency: start accepted at edge k; busy=1 from after edge k up to edge k+33; hi/lo/done update at edge k+33; a new start can be accepted at edge k+34.
- done is high exactly one cycle; busy=0 during that cycle.
- hi/lo hold their previous values throughout RUN.
- Operands are sampled only on the accepting edge, so later changes on rs_data/rt_data have no effect.
- The register file returns read data one cycle after the address, so the issue logic asserts start one cycle after presenting rs/rt.

## Structure
- Shared package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum (IDLE, RUN, FIX);
  - the ITERATIONS=32 constant.
- One combinational sub-module, muldiv_signfix, does abs/conditional-negate. It is used for operand capture and the FIX step.

## Test plan
- MULT rs=0xFFFFFFFD, rt=7 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse of 1 cycle.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=100.
- Second start and an mthi while busy -> both ignored, first result intact.
- rst at RUN cycle 10 -> busy=0, hi=lo=0 next cycle, no done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int ITERATIONS = 32;
  localparam int CNT_W      = $clog2(ITERATIONS);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; driving neg_i with the sign bit yields the magnitude.
// Purely combinational, no handshake.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] data_i,
  input  logic         neg_i,
  output logic [W-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + {{(W-1){1'b0}}, 1'b1}) : data_i;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide: 32 shift-add / restoring-divide steps plus a sign-fix cycle (33 cycles).
// start is ignored while busy; no queuing, no backpressure beyond the busy flag.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   opr_q, opr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign sgn_a = op_is_signed(op) & rs_data[WIDTH-1];
  assign sgn_b = op_is_signed(op) & rt_data[WIDTH-1];

  muldiv_signfix #(.W(WIDTH)) u_abs_a (.data_i(rs_data), .neg_i(sgn_a), .data_o(mag_a));
  muldiv_signfix #(.W(WIDTH)) u_abs_b (.data_i(rt_data), .neg_i(sgn_b), .data_o(mag_b));

  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .data_i(acc_q), .neg_i(neg_lo_q), .data_o(prod_fix)
  );
  muldiv_signfix #(.W(WIDTH)) u_fix_quot (
    .data_i(acc_q[WIDTH-1:0]), .neg_i(neg_lo_q), .data_o(quot_fix)
  );
  muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .data_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_hi_q), .data_o(rem_fix)
  );

  // Multiply: acc = {partial product, multiplier}; add in the top half, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opr_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend->quotient}; shift left, subtract if it fits.
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, opr_q};
  assign div_sub   = div_shift[WIDTH-1:0] - opr_q;
  assign div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    opr_d    = opr_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          div_d    = op_is_div(op);
          opr_d    = op_is_div(op) ? mag_b : mag_a;
          acc_d    = {{WIDTH{1'b0}}, (op_is_div(op) ? mag_a : mag_b)};
          neg_lo_d = sgn_a ^ sgn_b;
          neg_hi_d = sgn_a;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          if (mthi) hi_d = rs_data;
          if (mtlo) lo_d = rs_data;
        end
      end
      RUN: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERATIONS - 1)) state_d = FIX;
      end
      FIX: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opr_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      opr_q    <= opr_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: reference results queued at issue, compared on done.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference {hi, lo} from native wide arithmetic, MIPS divide-by-zero rules applied explicitly.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) p = {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with busy=0; returns at the negedge of the done cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    int          lat;
    bit          held;
    logic [31:0] hi0, lo0;
    logic [63:0] exp;
    hi0 = hi;
    lo0 = lo;
    held = 1'b1;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    sb_q.push_back(model(o, a, b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    check_val("done_pulse_width", 64'(done), 64'd0);
    check_val("busy_after_accept", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 40) begin
      if (poke && lat == 5) begin
        start = 1'b1; op = ~o; mthi = 1'b1; mtlo = 1'b1;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (!done && (hi !== hi0 || lo !== lo0)) held = 1'b0;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check_val("latency", 64'(lat), 64'd33);
    check_val("hilo_held_in_run", 64'(held), 64'd1);
    check_val("busy_in_done", 64'(busy), 64'd0);
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      check_val("hi", 64'(hi), 64'(exp[63:32]));
      check_val("lo", 64'(lo), 64'(exp[31:0]));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_hi", 64'(hi), 64'd0);
    check_val("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;

    // Direct HI/LO writes in IDLE.
    mthi = 1'b1; rs_data = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    check_val("mthi_hi", 64'(hi), 64'h1234_5678);
    check_val("mthi_lo", 64'(lo), 64'd0);
    mtlo = 1'b1; rs_data = 32'hCAFE_0001;
    @(negedge clk);
    mtlo = 1'b0;
    check_val("mtlo_lo", 64'(lo), 64'hCAFE_0001);
    check_val("mtlo_hi", 64'(hi), 64'h1234_5678);
    mthi = 1'b1; mtlo = 1'b1; rs_data = 32'h0BAD_F00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check_val("mthilo_hi", 64'(hi), 64'h0BAD_F00D);
    check_val("mthilo_lo", 64'(lo), 64'h0BAD_F00D);

    // Directed cases, back to back; the first also asserts mthi/mtlo with the accepted start.
    mthi = 1'b1; mtlo = 1'b1;
    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b11, 32'd100,       32'd0,         1'b0);
    do_op(2'b10, 32'hFFFF_FF00, 32'd0,         1'b0);
    do_op(2'b10, 32'd12345,     32'd0,         1'b0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(2'b01, 32'h0001_2345, 32'h0006_789A, 1'b1);

    for (int i = 0; i < 16; i++) begin
      logic [1:0] ro;
      ro = 2'($urandom_range(0, 3));
      do_op(ro, pick(), pick(), (i % 5) == 0);
    end

    // Abort mid-run: previous result is non-zero, reset must clear it with no done.
    op = 2'b00; rs_data = 32'h0000_0003; rt_data = 32'h0000_0005; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_hi", 64'(hi), 64'd0);
    check_val("abort_lo", 64'(lo), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_val("abort_no_done", 64'(saw_done), 64'd0);

    do_op(2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    @(negedge clk);
    check_val("final_done_width", 64'(done), 64'd0);
    check_val("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
